// File: rtl/mem_nrnw_helper.sv
// -----------------------------------------------------------------------------
// mem_nrnw_helper
//
// Multi-port behavioural memory model. It serves as the backing store behind
// the memory-side bus adapters when the DPI-C RAM path is not built in.
// Reads are pipelined with a per-port valid. Writes are bit-masked and merged
// in ascending port order. The first out-of-range access after reset is
// recorded in a sticky flag.
//
// Build option:
//   MEM_HELPER_BYPASS_EN  when defined, a read sampled at the same edge as
//                         writes to the same word returns the fully merged
//                         post-write word. When undefined, the read returns
//                         the old word (read-first).
//
// Parameters:
//   RAM_SIZE      memory size in bytes (multiple of DATA_WIDTH/8)
//   DATA_WIDTH    word width in bits (power of two, 8..512)
//   N_READ        number of read ports (1..8)
//   N_WRITE       number of write ports (1..8)
//   READ_LATENCY  cycles from a sampled read enable to valid data (1..4)
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset
//   r_enable    per-port read request
//   r_index     64-bit word index per read port, port i at [64*i +: 64]
//   r_data      read data per port; holds its value between valid pulses
//   r_valid     one-cycle pulse per port when new read data is presented
//   w_enable    per-port write request
//   w_index     64-bit word index per write port
//   w_data      write data per port
//   w_mask      per-bit write mask per port (1 = write that bit)
//   oob_error   sticky out-of-range flag
//   oob_port    first offending port: bit 7 = write, bits 6:0 = port number
// -----------------------------------------------------------------------------
module mem_nrnw_helper #(
   parameter int unsigned RAM_SIZE     = 8388608,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned N_READ       = 2,
   parameter int unsigned N_WRITE      = 2,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [N_READ-1:0]              r_enable,
   input  logic [N_READ*64-1:0]           r_index,
   output logic [N_READ*DATA_WIDTH-1:0]   r_data,
   output logic [N_READ-1:0]              r_valid,
   input  logic [N_WRITE-1:0]             w_enable,
   input  logic [N_WRITE*64-1:0]          w_index,
   input  logic [N_WRITE*DATA_WIDTH-1:0]  w_data,
   input  logic [N_WRITE*DATA_WIDTH-1:0]  w_mask,
   output logic                           oob_error,
   output logic [7:0]                     oob_port
);

   localparam int unsigned DEPTH   = RAM_SIZE / (DATA_WIDTH / 8);
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] DEPTH_W = 64'(DEPTH);
   localparam int unsigned LAST    = READ_LATENCY - 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [N_READ-1:0]                   r_ok;
   logic [N_READ-1:0][AW-1:0]           r_addr;
   logic [N_WRITE-1:0]                  w_ok;
   logic [N_WRITE-1:0][AW-1:0]          w_addr;
   logic [N_WRITE-1:0][DATA_WIDTH-1:0]  w_word;
   logic [N_READ-1:0][DATA_WIDTH-1:0]   rd_word;
   logic                                err_hit;
   logic [7:0]                          err_code;

   // Read pipeline: stage LAST drives the outputs directly.
   logic [READ_LATENCY-1:0][N_READ-1:0]  pv;
   logic [N_READ-1:0][DATA_WIDTH-1:0]    pd [READ_LATENCY];
   logic [READ_LATENCY-1:0][N_READ-1:0]  sv_in;
   logic [N_READ-1:0][DATA_WIDTH-1:0]    sd_in [READ_LATENCY];

   // The full 64-bit index is range-checked. Only the low AW bits address
   // the array.
   always_comb begin
      for (int unsigned i = 0; i < N_READ; i++) begin
         r_ok[i]   = r_index[64*i +: 64] < DEPTH_W;
         r_addr[i] = r_index[64*i +: AW];
      end
      for (int unsigned j = 0; j < N_WRITE; j++) begin
         w_ok[j]   = w_index[64*j +: 64] < DEPTH_W;
         w_addr[j] = w_index[64*j +: AW];
      end
   end

   // w_word[j] holds the word at w_addr[j] after writes from ports 0..j have
   // been applied in order. For a word targeted by several ports, the
   // highest such port therefore carries the complete merge.
   always_comb begin
      for (int unsigned j = 0; j < N_WRITE; j++) begin
         w_word[j] = mem[w_addr[j]];
         for (int unsigned k = 0; k <= j; k++) begin
            if (w_enable[k] && w_ok[k] && (w_addr[k] == w_addr[j])) begin
               w_word[j] = (w_data[DATA_WIDTH*k +: DATA_WIDTH] & w_mask[DATA_WIDTH*k +: DATA_WIDTH])
                         | (w_word[j] & ~w_mask[DATA_WIDTH*k +: DATA_WIDTH]);
            end
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_READ; i++) begin
         rd_word[i] = '0;
         if (r_ok[i]) begin
            rd_word[i] = mem[r_addr[i]];
`ifdef MEM_HELPER_BYPASS_EN
            // The last matching port overrides earlier ones and carries the
            // full merge.
            for (int unsigned j = 0; j < N_WRITE; j++) begin
               if (w_enable[j] && w_ok[j] && (w_addr[j] == r_addr[i])) begin
                  rd_word[i] = w_word[j];
               end
            end
`endif
         end
      end
   end

   // Find the first offending port: writes first (lowest port number first),
   // then reads.
   always_comb begin
      err_hit  = 1'b0;
      err_code = '0;
      for (int unsigned j = 0; j < N_WRITE; j++) begin
         if (!err_hit && w_enable[j] && !w_ok[j]) begin
            err_hit  = 1'b1;
            err_code = {1'b1, 7'(j)};
         end
      end
      for (int unsigned i = 0; i < N_READ; i++) begin
         if (!err_hit && r_enable[i] && !r_ok[i]) begin
            err_hit  = 1'b1;
            err_code = {1'b0, 7'(i)};
         end
      end
   end

   // Same-word writes in one cycle issue several NBAs to one location. The
   // last one (highest port) lands, and that port carries the merged word.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int unsigned j = 0; j < N_WRITE; j++) begin
            if (w_enable[j] && w_ok[j]) begin
               mem[w_addr[j]] <= w_word[j];
            end
         end
      end
   end

   always_comb begin
      sv_in[0] = r_enable;
      sd_in[0] = rd_word;
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
         sv_in[s] = pv[s-1];
         sd_in[s] = pd[s-1];
      end
   end

   // Data in every stage is loaded only with a valid result. The last stage
   // therefore holds its value between pulses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pv        <= '0;
         oob_error <= 1'b0;
         oob_port  <= '0;
         for (int unsigned s = 0; s < READ_LATENCY; s++) begin
            pd[s] <= '0;
         end
      end else begin
         pv <= sv_in;
         for (int unsigned s = 0; s < READ_LATENCY; s++) begin
            for (int unsigned i = 0; i < N_READ; i++) begin
               if (sv_in[s][i]) begin
                  pd[s][i] <= sd_in[s][i];
               end
            end
         end
         if (!oob_error && err_hit) begin
            oob_error <= 1'b1;
            oob_port  <= err_code;
         end
      end
   end

   always_comb begin
      r_valid = pv[LAST];
      for (int unsigned i = 0; i < N_READ; i++) begin
         r_data[DATA_WIDTH*i +: DATA_WIDTH] = pd[LAST][i];
      end
   end

endmodule

// File: tb/tb_mem_nrnw_helper.sv
module tb_mem_nrnw_helper;

   localparam int unsigned RS    = 1024;
   localparam int unsigned DW    = 64;
   localparam int unsigned NR    = 2;
   localparam int unsigned NW    = 2;
   localparam int unsigned RL    = 2;
   localparam int unsigned DEPTH = 128;

   logic                 clock = 1'b0;
   logic                 reset_n;
   logic [NR-1:0]        r_enable;
   logic [NR*64-1:0]     r_index;
   logic [NR*DW-1:0]     r_data;
   logic [NR-1:0]        r_valid;
   logic [NW-1:0]        w_enable;
   logic [NW*64-1:0]     w_index;
   logic [NW*DW-1:0]     w_data;
   logic [NW*DW-1:0]     w_mask;
   logic                 oob_error;
   logic [7:0]           oob_port;

   always #5 clock = ~clock;

   mem_nrnw_helper #(
      .RAM_SIZE     (RS),
      .DATA_WIDTH   (DW),
      .N_READ       (NR),
      .N_WRITE      (NW),
      .READ_LATENCY (RL)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .r_enable  (r_enable),
      .r_index   (r_index),
      .r_data    (r_data),
      .r_valid   (r_valid),
      .w_enable  (w_enable),
      .w_index   (w_index),
      .w_data    (w_data),
      .w_mask    (w_mask),
      .oob_error (oob_error),
      .oob_port  (oob_port)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: a word array plus a per-port queue of pending results.
   logic [63:0]  m_mem [DEPTH];
   logic [64:0]  pend [NR][$];
   logic [63:0]  m_data [NR];
   logic [NR-1:0] exp_valid;
   logic         m_err;
   logic [7:0]   m_port;
   int unsigned  pulses [NR];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      r_enable = '0;
      w_enable = '0;
   endtask

   task automatic set_w(input int unsigned j, input logic [63:0] idx,
                        input logic [63:0] d, input logic [63:0] m);
      w_enable[j]          = 1'b1;
      w_index[64*j +: 64]  = idx;
      w_data[DW*j +: DW]   = d;
      w_mask[DW*j +: DW]   = m;
   endtask

   task automatic set_r(input int unsigned i, input logic [63:0] idx);
      r_enable[i]         = 1'b1;
      r_index[64*i +: 64] = idx;
   endtask

   // Advance one edge, update the model with what the DUT sampled, then check.
   task automatic step();
      logic [63:0] idx;
      logic [63:0] rd [NR];
      logic [64:0] e;
      logic [63:0] d;
      logic [63:0] m;
      @(posedge clock);
      if (!reset_n) begin
         for (int i = 0; i < NR; i++) begin
            pend[i].delete();
            m_data[i] = '0;
         end
         exp_valid = '0;
         m_err     = 1'b0;
         m_port    = '0;
      end else begin
         for (int j = 0; j < NW; j++) begin
            idx = w_index[64*j +: 64];
            if (!m_err && w_enable[j] && idx >= 64'(DEPTH)) begin
               m_err  = 1'b1;
               m_port = 8'h80 | 8'(j);
            end
         end
         for (int i = 0; i < NR; i++) begin
            idx = r_index[64*i +: 64];
            if (!m_err && r_enable[i] && idx >= 64'(DEPTH)) begin
               m_err  = 1'b1;
               m_port = 8'(i);
            end
         end
         for (int i = 0; i < NR; i++) begin
            idx   = r_index[64*i +: 64];
            rd[i] = '0;
            if (idx < 64'(DEPTH)) rd[i] = m_mem[idx[6:0]];
         end
         for (int j = 0; j < NW; j++) begin
            idx = w_index[64*j +: 64];
            d   = w_data[DW*j +: DW];
            m   = w_mask[DW*j +: DW];
            if (w_enable[j] && idx < 64'(DEPTH))
               m_mem[idx[6:0]] = (d & m) | (m_mem[idx[6:0]] & ~m);
         end
`ifdef MEM_HELPER_BYPASS_EN
         for (int i = 0; i < NR; i++) begin
            idx = r_index[64*i +: 64];
            if (idx < 64'(DEPTH)) rd[i] = m_mem[idx[6:0]];
         end
`endif
         for (int i = 0; i < NR; i++) begin
            pend[i].push_back(r_enable[i] ? {1'b1, rd[i]} : 65'd0);
            exp_valid[i] = 1'b0;
            if (pend[i].size() >= RL) begin
               e = pend[i].pop_front();
               exp_valid[i] = e[64];
               if (e[64]) m_data[i] = e[63:0];
            end
         end
      end
      #1;
      for (int i = 0; i < NR; i++) begin
         check($sformatf("r_valid%0d", i), 64'(r_valid[i]), 64'(exp_valid[i]));
         check($sformatf("r_data%0d", i), r_data[64*i +: 64], m_data[i]);
         pulses[i] += 32'(r_valid[i]);
      end
      check("oob_error", 64'(oob_error), 64'(m_err));
      check("oob_port", 64'(oob_port), 64'(m_port));
   endtask

   function automatic logic [63:0] rnd_idx();
      int unsigned p;
      p = $urandom_range(99);
      if (p < 60) return 64'($urandom_range(7));
      if (p < 96) return 64'($urandom_range(127));
      if (p < 98) return 64'd128;
      return {$urandom, $urandom} | 64'h1_0000_0000;
   endfunction

   function automatic logic [63:0] rnd_mask();
      if ($urandom_range(1) == 0) return '1;
      return {$urandom, $urandom};
   endfunction

   initial begin
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      for (int i = 0; i < NR; i++) begin
         m_data[i] = '0;
         pulses[i] = 0;
      end
      exp_valid = '0;
      m_err     = 1'b0;
      m_port    = '0;
      r_index   = '0;
      w_index   = '0;
      w_data    = '0;
      w_mask    = '0;
      idle();

      // Reset for two cycles.
      reset_n = 1'b0;
      step();
      step();
      check("rst_valid", 64'(r_valid), 64'd0);
      check("rst_data", r_data[63:0], 64'd0);
      reset_n = 1'b1;

      // Zero-fill the array so DUT and model agree on every word.
      for (int k = 0; k < DEPTH / 2; k++) begin
         idle();
         set_w(0, 64'(2 * k), '0, '1);
         set_w(1, 64'(2 * k + 1), '0, '1);
         step();
      end

      // Basic latency.
      idle();
      set_w(0, 64'd5, 64'h1122334455667788, '1);
      step();
      idle();
      set_r(1, 64'd5);
      step();
      check("lat_early", 64'(r_valid), 64'd0);
      idle();
      step();
      check("lat_valid", 64'(r_valid), 64'b10);
      check("lat_data", r_data[127:64], 64'h1122334455667788);
      step();
      check("lat_pulse_end", 64'(r_valid), 64'd0);

      // Masked merge from two ports into one word.
      set_w(0, 64'd7, '1, '1);
      step();
      idle();
      set_w(0, 64'd7, 64'h0, 64'h0000_0000_FFFF_FFFF);
      set_w(1, 64'd7, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_FFFF_FFFF_0000);
      step();
      idle();
      set_r(0, 64'd7);
      step();
      idle();
      step();
      check("merge", r_data[63:0], 64'hFFFF_AAAA_AAAA_0000);

      // Read-during-write.
      set_w(0, 64'd3, 64'h10, '1);
      step();
      idle();
      set_w(0, 64'd3, 64'h20, '1);
      set_r(0, 64'd3);
      step();
      idle();
      set_r(0, 64'd3);
      step();
`ifdef MEM_HELPER_BYPASS_EN
      check("rdw_same", r_data[63:0], 64'h20);
`else
      check("rdw_same", r_data[63:0], 64'h10);
`endif
      idle();
      step();
      check("rdw_next", r_data[63:0], 64'h20);

      // Out of range.
      set_w(0, 64'd0, 64'hDEAD_BEEF, '1);
      step();
      idle();
      set_w(1, 64'd128, 64'h5555_5555_5555_5555, '1);
      step();
      check("oob_w_flag", 64'(oob_error), 64'd1);
      check("oob_w_port", 64'(oob_port), 64'h81);
      idle();
      set_r(0, 64'd200);
      set_r(1, 64'd0);
      step();
      idle();
      step();
      check("oob_r_valid", 64'(r_valid), 64'b11);
      check("oob_r_data", r_data[63:0], 64'd0);
      check("oob_unchanged", r_data[127:64], 64'hDEAD_BEEF);
      check("oob_r_port", 64'(oob_port), 64'h81);

      // Reset while a read is in flight.
      set_r(0, 64'd5);
      step();
      idle();
      reset_n = 1'b0;
      step();
      check("mid_valid", 64'(r_valid), 64'd0);
      check("mid_data", r_data[63:0], 64'd0);
      check("mid_oob", 64'(oob_error), 64'd0);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) step();
      set_r(0, 64'd5);
      step();
      idle();
      step();
      check("retained", r_data[63:0], 64'h1122334455667788);

      // Streaming on all ports.
      for (int i = 0; i < NR; i++) pulses[i] = 0;
      for (int k = 0; k < 16; k++) begin
         set_r(0, 64'(k));
         set_r(1, 64'(k));
         step();
      end
      idle();
      for (int k = 0; k < RL + 1; k++) step();
      check("stream_p0", 64'(pulses[0]), 64'd16);
      check("stream_p1", 64'(pulses[1]), 64'd16);

      // Randomised traffic with periodic resets.
      for (int c = 0; c < 600; c++) begin
         reset_n = (c % 150 == 149) ? 1'b0 : 1'b1;
         for (int i = 0; i < NR; i++) begin
            r_enable[i]         = ($urandom_range(2) != 0);
            r_index[64*i +: 64] = rnd_idx();
         end
         for (int j = 0; j < NW; j++) begin
            w_enable[j]         = ($urandom_range(1) != 0);
            w_index[64*j +: 64] = rnd_idx();
            w_data[DW*j +: DW]  = {$urandom, $urandom};
            w_mask[DW*j +: DW]  = rnd_mask();
         end
         step();
      end
      reset_n = 1'b1;
      idle();
      for (int k = 0; k < RL + 1; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_nrnw_helper.md
# mem_nrnw_helper

Parametrised multi-port behavioural memory model for simulation and emulation builds. It is the successor to the single-read/single-write helper: configurable data width, read and write port counts, and read latency, plus out-of-range detection. It sits in the SoC simulation top as the backing store behind the memory-side bus adapters, in builds where the DPI-C RAM path is disabled. Reads are pipelined with per-port valid; writes are bit-masked and merged deterministically across ports.

## Interface
Parameters:
- RAM_SIZE, 8388608 — memory size in bytes; must be a multiple of DATA_WIDTH/8.
- DATA_WIDTH, 64 — word width in bits; power of two, 8..512.
- N_READ, 2 — number of read ports, 1..8.
- N_WRITE, 2 — number of write ports, 1..8.
- READ_LATENCY, 1 — cycles from a sampled read enable to valid data, 1..4.

Ports:
- clock  in  1  sole clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- r_enable  in  N_READ  per-port read request.
- r_index  in  N_READ*64  word index per port; port i occupies bits [64*i +: 64].
- r_data  out  N_READ*DATA_WIDTH  read data per port.
- r_valid  out  N_READ  one-cycle pulse per port when r_data carries a new result.
- w_enable  in  N_WRITE  per-port write request.
- w_index  in  N_WRITE*64  word index per write port.
- w_data  in  N_WRITE*DATA_WIDTH  write data.
- w_mask  in  N_WRITE*DATA_WIDTH  bit mask; 1 means write that bit.
- oob_error  out  1  sticky flag for an out-of-range access.
- oob_port  out  8  encodes the first offending port: bit 7 = 1 for a write, bits 6:0 = port number.

## Operation
- Depth: DEPTH = RAM_SIZE / (DATA_WIDTH/8) words. An index is valid when index < DEPTH. All 64 index bits are compared, not truncated.
- Read: when r_enable[i] is high at an edge, array[r_index[i]] is sampled at that edge. The value then passes through a READ_LATENCY-deep pipeline (data plus valid) per port.
- Out-of-range read: returns all-zero data and still pulses r_valid.
- Data hold: r_data[i] keeps its last value between valid pulses.
- Write: when w_enable[j] is high, the new word = (w_data & w_mask) | (old & ~w_mask).
- Multiple writes to the same word in one cycle: applied in ascending port order, so for overlapping mask bits the highest-numbered port wins. Disjoint mask bits from all ports take effect.
- Out-of-range write: dropped; the array is unchanged.
- Error capture: the first out-of-range access after reset sets oob_error and latches oob_port. Later errors do not change either until the next reset.
- Same-cycle priority for oob_port: writes (lowest port first) are reported before reads (lowest port first).
- Memory contents are not initialised or cleared by reset. A zero-filled array at time 0 is acceptable.
- Read-during-write (same word, same edge): returns the pre-write word, unless MEM_HELPER_BYPASS_EN is defined (see Configuration).

## Timing
- Reset values: r_data = 0, r_valid = 0, oob_error = 0, oob_port = 0; all read pipeline stages are cleared.
- Reset takes effect at the first edge with reset_n low. In-flight reads are discarded and never produce r_valid.
- While reset_n is low: writes are ignored, read enables are ignored, and no errors are recorded.
- Latency: enable sampled at edge T gives r_valid high and r_data updated in the cycle after edge T+READ_LATENCY-1. With READ_LATENCY=1 this is the cycle immediately after the request.
- Throughput: one read per port per cycle and one write per port per cycle; there is no back-pressure.
- A write at edge T is visible to a read sampled at edge T+1 or later.

## Configuration
- MEM_HELPER_BYPASS_EN defined: read-during-write forwarding.
  - A read sampled at the same edge as writes to the same word returns the fully merged post-write word (all ports, with port-order priority).
  - Latency is unchanged.
- MEM_HELPER_BYPASS_EN undefined: read-first; same-edge reads return the old word.
- No other behaviour differs between the two builds.

## Test plan
- Reset and basic latency: reset_n=0 for 2 cycles, then N_READ=2, READ_LATENCY=2. Write index 5 = 0x1122334455667788 with an all-ones mask; then read port 1 at index 5 → r_valid[1] pulses exactly 2 cycles later with data 0x1122334455667788; r_valid[0] stays 0.
- Masked write merge: start with word 7 = 0xFFFF_FFFF_FFFF_FFFF. Same cycle: port 0 writes 0x0 with mask 0x0000_0000_FFFF_FFFF, and port 1 writes 0xAAAA_AAAA_AAAA_AAAA with mask 0x0000_FFFF_FFFF_0000 → a read returns 0xFFFF_AAAA_AAAA_0000.
- Read-during-write on index 3 (old 0x10, new 0x20): without the macro the read returns 0x10; with MEM_HELPER_BYPASS_EN it returns 0x20. A read the following cycle returns 0x20 in both builds.
- Out of range with RAM_SIZE=1024, DATA_WIDTH=64 (DEPTH=128):
  - Write port 1 at index 128 → array unchanged, oob_error=1, oob_port=0x81.
  - A later read port 0 at index 200 → data 0, r_valid pulses, oob_port stays 0x81.
- Reset mid-flight with READ_LATENCY=3: issue a read, assert reset_n=0 one cycle later → no r_valid ever appears for it. r_data=0 and oob_error=0 after reset, while array contents are retained.
- Back-to-back streaming: 16 consecutive cycles of reads on all ports at indices 0..15 → 16 consecutive r_valid pulses per port, with data in issue order.
